// File: rtl/arith_pkg.sv
// Shared definitions for the pipelined add/sub/abs unit.
// Holds the opcode encodings and the signed-limit helper functions.
// Opcode aliases exist because two encodings map onto add, |A| and |B|.
package arith_pkg;

  localparam logic [2:0] OP_ADD0  = 3'b000;
  localparam logic [2:0] OP_ASUBB = 3'b001;
  localparam logic [2:0] OP_ABSB0 = 3'b010;
  localparam logic [2:0] OP_ABSB1 = 3'b011;
  localparam logic [2:0] OP_ADD1  = 3'b100;
  localparam logic [2:0] OP_BSUBA = 3'b101;
  localparam logic [2:0] OP_ABSA0 = 3'b110;
  localparam logic [2:0] OP_ABSA1 = 3'b111;

  // Largest positive two's-complement value for a w-bit word, zero-extended.
  function automatic logic [63:0] max_pos(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value for a w-bit word (low w bits valid).
  function automatic logic [63:0] min_neg(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/arith_unit_addsub.sv
// Purpose: combinational WIDTH-bit adder/subtractor with signed overflow flag.
// Latency: 0 cycles (pure combinational). Backpressure: none, no state.
// Ports: x, y operands; sub selects x + ~y + 1; sum/cout result; ovf signed overflow.
module addsub_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] y_eff;

  assign y_eff       = sub ? ~y : y;
  assign {cout, sum} = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, sub};
  // Overflow is judged on the operands actually summed (x and the possibly
  // inverted y), which is exactly the classic same-sign-in, other-sign-out rule.
  assign ovf = (x[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);

endmodule

// File: rtl/arith_unit_pipe.sv
// Purpose: two-stage signed add / A-B / B-A / |A| / |B| with overflow and optional saturation.
// Latency: 2 cycles from accepted input beat to out_valid; 1 beat/cycle throughput.
// Backpressure: valid/ready on both sides; a stall at out_ready ripples back one stage per cycle.
// Ports: clk, rst_n (async, active low); in_valid/in_ready/in_a/in_b/in_op input beat;
//        out_valid/out_ready/out_r/out_ovf/out_sat result beat.
module arith_unit_pipe
  import arith_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter bit SAT_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic             out_ovf,
  output logic             out_sat
);

  // Stage-1 payload: operands already swapped into place plus the op flags.
  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             sub;
    logic             abs;
  } s1_pay_t;

  s1_pay_t          s1_nxt;
  s1_pay_t          s1_q;
  logic             s1_vld;
  logic             s2_vld;
  logic             s1_adv;

  logic [WIDTH-1:0] core_x;
  logic [WIDTH-1:0] core_y;
  logic             core_sub;
  logic [WIDTH-1:0] core_sum;
  logic             core_cout_unused;
  logic             core_ovf;
  logic [WIDTH-1:0] sat_val;
  logic [WIDTH-1:0] res;
  logic             res_sat;

  // Handshake: stage 2 empties when empty or draining; stage 1 accepts
  // whenever it is empty or can move forward.
  assign s1_adv    = ~s2_vld | out_ready;
  assign in_ready  = ~s1_vld | s1_adv;
  assign out_valid = s2_vld;

  // Decode: B-A is A-B with the operands swapped; |A| and |B| select X.
  always_comb begin
    s1_nxt = '0;
    case (in_op)
      OP_ADD0, OP_ADD1: begin
        s1_nxt.x = in_a;
        s1_nxt.y = in_b;
      end
      OP_ASUBB: begin
        s1_nxt.x   = in_a;
        s1_nxt.y   = in_b;
        s1_nxt.sub = 1'b1;
      end
      OP_BSUBA: begin
        s1_nxt.x   = in_b;
        s1_nxt.y   = in_a;
        s1_nxt.sub = 1'b1;
      end
      OP_ABSA0, OP_ABSA1: begin
        s1_nxt.x   = in_a;
        s1_nxt.abs = 1'b1;
      end
      default: begin  // OP_ABSB0, OP_ABSB1
        s1_nxt.x   = in_b;
        s1_nxt.abs = 1'b1;
      end
    endcase
  end

  // Abs reuses the adder as 0 - X (negative X) or 0 + X (non-negative X), so
  // |most-negative| falls out of the same overflow rule as subtraction.
  always_comb begin
    core_x   = s1_q.x;
    core_y   = s1_q.y;
    core_sub = s1_q.sub;
    if (s1_q.abs) begin
      core_x   = '0;
      core_y   = s1_q.x;
      core_sub = s1_q.x[WIDTH-1];
    end
  end

  addsub_core #(.WIDTH(WIDTH)) u_addsub (
    .x    (core_x),
    .y    (core_y),
    .sub  (core_sub),
    .sum  (core_sum),
    .cout (core_cout_unused),
    .ovf  (core_ovf)
  );

  // On overflow the wrapped sign is the opposite of the true sign, so a
  // negative wrapped sum means the true result was too large a positive.
  assign sat_val = core_sum[WIDTH-1] ? WIDTH'(max_pos(WIDTH)) : WIDTH'(min_neg(WIDTH));
  assign res_sat = SAT_EN && core_ovf;
  assign res     = res_sat ? sat_val : core_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_q    <= '0;
      s2_vld  <= 1'b0;
      out_r   <= '0;
      out_ovf <= 1'b0;
      out_sat <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_vld <= in_valid;
      end
      if (in_valid && in_ready) begin
        s1_q <= s1_nxt;
      end
      if (s1_adv) begin
        s2_vld <= s1_vld;
      end
      // Result registers load only with a real beat so a stalled or drained
      // output keeps its last value.
      if (s1_vld && s1_adv) begin
        out_r   <= res;
        out_ovf <= core_ovf;
        out_sat <= res_sat;
      end
    end
  end

endmodule

// File: tb/tb_arith_unit_pipe.sv
module tb_arith_unit_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Two 4-bit units (wrap and saturate) share one stimulus stream.
  logic       d_vld, d_ordy;
  logic [3:0] d_a, d_b;
  logic [2:0] d_op;
  logic       rdy0, ov0, of0, sf0;
  logic [3:0] r0;
  logic       rdy1, ov1, of1, sf1;
  logic [3:0] r1;

  // 16-bit saturating unit for the random regression.
  logic        w_vld, w_ordy;
  logic [15:0] w_a, w_b;
  logic [2:0]  w_op;
  logic        rdy2, ov2, of2, sf2;
  logic [15:0] r2;

  arith_unit_pipe #(.WIDTH(4), .SAT_EN(1'b0)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(d_vld), .in_ready(rdy0),
    .in_a(d_a), .in_b(d_b), .in_op(d_op), .out_valid(ov0), .out_ready(d_ordy),
    .out_r(r0), .out_ovf(of0), .out_sat(sf0));

  arith_unit_pipe #(.WIDTH(4), .SAT_EN(1'b1)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(d_vld), .in_ready(rdy1),
    .in_a(d_a), .in_b(d_b), .in_op(d_op), .out_valid(ov1), .out_ready(d_ordy),
    .out_r(r1), .out_ovf(of1), .out_sat(sf1));

  arith_unit_pipe #(.WIDTH(16), .SAT_EN(1'b1)) u_s16 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_vld), .in_ready(rdy2),
    .in_a(w_a), .in_b(w_b), .in_op(w_op), .out_valid(ov2), .out_ready(w_ordy),
    .out_r(r2), .out_ovf(of2), .out_sat(sf2));

  typedef struct packed {
    logic [15:0] r;
    logic        ovf;
    logic        sat;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  exp_t        q[3][$];
  int          tx[3];
  int          rx[3];
  logic        stall[3];
  logic [17:0] held[3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic, then range-check against w bits.
  function automatic exp_t model(input int w, input bit se, input logic [15:0] a,
                                 input logic [15:0] b, input logic [2:0] op);
    longint sa, sb, t, mx, mn, msk;
    exp_t   e;
    msk = (longint'(1) << w) - 1;
    mx  = msk >> 1;
    mn  = -mx - 1;
    sa  = longint'(a) & msk;
    sb  = longint'(b) & msk;
    if (sa > mx) sa = sa - (msk + 1);
    if (sb > mx) sb = sb - (msk + 1);
    case (op)
      3'd0, 3'd4: t = sa + sb;
      3'd1:       t = sa - sb;
      3'd5:       t = sb - sa;
      3'd6, 3'd7: t = (sa < 0) ? -sa : sa;
      default:    t = (sb < 0) ? -sb : sb;
    endcase
    e.ovf = (t > mx) || (t < mn);
    e.sat = e.ovf && se;
    if (e.sat) t = (t > 0) ? mx : mn;
    e.r = 16'(t & msk);
    return e;
  endfunction

  task automatic mon(input int k, input int w, input bit se, input logic iv, input logic ir,
                     input logic [15:0] ia, input logic [15:0] ib, input logic [2:0] iop,
                     input logic ov, input logic ordy, input logic [15:0] r,
                     input logic of, input logic sf);
    exp_t e;
    if (!rst_n) begin
      q[k].delete();
      stall[k] = 1'b0;
      return;
    end
    if (stall[k]) chk($sformatf("hold%0d", k), 32'({ov, r, of, sf}), 32'({1'b1, held[k]}));
    if (ov && ordy) begin
      rx[k]++;
      if (q[k].size() == 0) chk($sformatf("spurious%0d", k), 32'd1, 32'd0);
      else begin
        e = q[k].pop_front();
        chk($sformatf("res%0d", k), 32'({r, of, sf}), 32'(e));
      end
    end
    stall[k] = ov && !ordy;
    held[k]  = {r, of, sf};
    if (iv && ir) begin
      q[k].push_back(model(w, se, ia, ib, iop));
      tx[k]++;
    end
  endtask

  always @(negedge clk) begin
    mon(0, 4, 1'b0, d_vld, rdy0, {12'd0, d_a}, {12'd0, d_b}, d_op, ov0, d_ordy, {12'd0, r0}, of0, sf0);
    mon(1, 4, 1'b1, d_vld, rdy1, {12'd0, d_a}, {12'd0, d_b}, d_op, ov1, d_ordy, {12'd0, r1}, of1, sf1);
    mon(2, 16, 1'b1, w_vld, rdy2, w_a, w_b, w_op, ov2, w_ordy, r2, of2, sf2);
  end

  // Offer one beat to the 4-bit pair; called just after a rising edge,
  // returns just after the edge that accepted it.
  task automatic put(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    int n;
    n = 0;
    d_a = a; d_b = b; d_op = op; d_vld = 1'b1;
    @(negedge clk);
    while (!rdy0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rdy0) chk("put_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    d_vld = 1'b0;
  endtask

  // One directed beat with literal expectations {r, ovf, sat} for wrap / saturate.
  task automatic dir(input string nm, input logic [2:0] op, input logic [3:0] a,
                     input logic [3:0] b, input logic [5:0] e0, input logic [5:0] e1);
    put(a, b, op);
    @(negedge clk);
    chk({nm, "_early"}, 32'({ov0, ov1}), 32'd0);
    @(negedge clk);
    chk({nm, "_vld"}, 32'({ov0, ov1}), 32'b11);
    chk({nm, "_wrap"}, 32'({r0, of0, sf0}), 32'(e0));
    chk({nm, "_sat"}, 32'({r1, of1, sf1}), 32'(e1));
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      4:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  base;
    int  sent;
    bit  take;
    rst_n = 1'b0;
    d_vld = 1'b0; d_ordy = 1'b1; d_a = '0; d_b = '0; d_op = '0;
    w_vld = 1'b0; w_ordy = 1'b1; w_a = '0; w_b = '0; w_op = '0;
    for (int i = 0; i < 3; i++) begin tx[i] = 0; rx[i] = 0; stall[i] = 1'b0; held[i] = '0; end

    // Pin the reference model itself.
    chk("model_absmin", 32'(model(4, 1'b1, 16'h8, 16'h0, 3'b110)), 32'({16'h7, 2'b11}));
    chk("model_addwrap", 32'(model(16, 1'b0, 16'h7FFF, 16'h1, 3'b000)), 32'({16'h8000, 2'b10}));
    chk("model_sub", 32'(model(4, 1'b0, 16'h2, 16'h5, 3'b001)), 32'({16'hD, 2'b00}));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", 32'({rdy0, rdy1, rdy2}), 32'b111);
    chk("rst_vld", 32'({ov0, ov1, ov2}), 32'd0);
    chk("rst_r", 32'({r0, r1}), 32'd0);
    chk("rst_r16", 32'(r2), 32'd0);
    chk("rst_flags", 32'({of0, sf0, of1, sf1, of2, sf2}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    dir("add",     3'b000, 4'd3,    4'd4,    {4'b0111, 2'b00}, {4'b0111, 2'b00});
    dir("add_ovf", 3'b000, 4'd7,    4'd1,    {4'b1000, 2'b10}, {4'b0111, 2'b11});
    dir("asubb",   3'b001, 4'd2,    4'd5,    {4'b1101, 2'b00}, {4'b1101, 2'b00});
    dir("bsuba",   3'b101, 4'd2,    4'd5,    {4'b0011, 2'b00}, {4'b0011, 2'b00});
    dir("absa_mn", 3'b110, 4'b1000, 4'd0,    {4'b1000, 2'b10}, {4'b0111, 2'b11});
    dir("absb",    3'b010, 4'd0,    4'b1010, {4'b0110, 2'b00}, {4'b0110, 2'b00});
    dir("add_neg", 3'b000, 4'b1000, 4'b1111, {4'b0111, 2'b10}, {4'b1000, 2'b11});
    dir("absa_p",  3'b111, 4'd5,    4'd9,    {4'b0101, 2'b00}, {4'b0101, 2'b00});
    dir("absb_n",  3'b011, 4'd0,    4'b1111, {4'b0001, 2'b00}, {4'b0001, 2'b00});
    dir("add1",    3'b100, 4'b1100, 4'd3,    {4'b1111, 2'b00}, {4'b1111, 2'b00});

    // Exhaustive 4-bit sweep, back to back, checked by the model.
    for (int op = 0; op < 8; op++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          put(4'(a), 4'(b), 3'(op));
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: 5 beats offered, output blocked for 4 cycles.
    base   = tx[0];
    d_ordy = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) put(4'(i + 6), 4'(2 * i + 1), 3'(i));
      end
    join_none
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bp_accepted", 32'(tx[0] - base), 32'd2);
    chk("bp_in_ready", 32'({rdy0, rdy1}), 32'd0);
    chk("bp_out_vld", 32'({ov0, ov1}), 32'b11);
    @(posedge clk); #1;
    d_ordy = 1'b1;
    wait fork;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bp_all_in", 32'(tx[0] - base), 32'd5);
    chk("bp_drained", 32'(q[0].size() + q[1].size()), 32'd0);
    chk("bp_rx_eq_tx", 32'(rx[0]), 32'(tx[0]));
    @(posedge clk); #1;

    // Reset while beats are in flight: nothing may emerge afterwards.
    d_ordy = 1'b0; d_vld = 1'b1; d_a = 4'd1; d_b = 4'd2; d_op = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; d_vld = 1'b0; d_ordy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flush_vld", 32'({ov0, ov1, ov2}), 32'd0);
    end
    chk("flush_r", 32'({r0, of0, sf0, r1, of1, sf1}), 32'd0);
    chk("flush_rdy", 32'({rdy0, rdy1, rdy2}), 32'b111);
    @(posedge clk); #1;

    // 16-bit random regression with random valid/ready.
    sent = 0;
    for (int cyc = 0; cyc < 60000 && sent < 10000; cyc++) begin
      @(negedge clk);
      take = w_vld && rdy2;
      @(posedge clk); #1;
      if (take) sent++;
      if (!w_vld || take) begin
        w_vld = (sent < 10000) && ($urandom_range(3) != 0);
        w_op  = 3'($urandom_range(7));
        w_a   = pick();
        w_b   = pick();
      end
      w_ordy = ($urandom_range(3) != 0);
    end
    chk("rnd_sent", 32'(sent), 32'd10000);
    w_vld = 1'b0; w_ordy = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rnd_rx", 32'(rx[2]), 32'd10000);
    chk("rnd_drained", 32'(q[2].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
